// File: rtl/ysyx_25060170_stage_reg.sv
// Generic valid/ready pipeline stage register with optional skid entry,
// multi-source flush, occupancy output and saturating stall counter.
//
// Ports:
//   clk, rst         clock, async active-low reset
//   in_valid/ready   upstream handshake, in_data payload
//   flush            flush requests (ORed)
//   out_valid/ready  downstream handshake, out_data payload
//   occ              entries held (0..2)
//   stall_cnt        saturating count of out_valid & ~out_ready cycles
//   stall_clr        synchronous clear of stall_cnt
module ysyx_25060170_stage_reg #(
  parameter int DATA_W  = 64,
  parameter int SKID_EN = 1,
  parameter int FLUSH_N = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [FLUSH_N-1:0] flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic w_rdy;
  logic w_acc;
  logic w_emit;
  logic w_flush;
  logic w_stall;

  assign out_valid = (r_state != S_EMPTY);

  // With the skid entry, ready depends only on
  // registered state, breaking the out_ready path.
  generate
    if (SKID_EN != 0) begin : g_skid
      assign w_rdy = (r_state != S_FULL);
    end else begin : g_noskid
      assign w_rdy = ~out_valid | out_ready;
    end
  endgenerate

  assign w_acc   = in_valid & w_rdy;
  assign w_emit  = out_valid & out_ready;
  assign w_flush = |flush;
  assign w_stall = out_valid & ~out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (w_flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = in_data;
          end
        end
        S_ONE: begin
          if (w_acc && w_emit) begin
            w_main_nxt = in_data;
          end else if (w_acc) begin
            // only reachable with the skid entry
            w_state_nxt = S_FULL;
            w_skid_nxt  = in_data;
          end else if (w_emit) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_emit) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (stall_clr) begin
      w_cnt_nxt = '0;
    end else if (w_stall && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign in_ready  = w_rdy;
  assign out_data  = r_main;
  assign occ       = r_state;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_ysyx_25060170_stage_reg.sv
// Directed bench for ysyx_25060170_stage_reg: skid instance (CNT_W=4)
// and no-skid instance (DATA_W=16) with a small scoreboard.
module tb_ysyx_25060170_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or, a_clr;
  logic [63:0] a_d, a_od;
  logic [2:0]  a_fl;
  logic [1:0]  a_occ;
  logic [3:0]  a_cnt;

  logic        b_iv, b_ir, b_ov, b_or, b_clr;
  logic [15:0] b_d, b_od;
  logic [2:0]  b_fl;
  logic [1:0]  b_occ;
  logic [15:0] b_cnt;

  ysyx_25060170_stage_reg #(
    .DATA_W(64), .SKID_EN(1), .FLUSH_N(3), .CNT_W(4)
  ) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .flush(a_fl),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occ(a_occ), .stall_cnt(a_cnt), .stall_clr(a_clr)
  );

  ysyx_25060170_stage_reg #(
    .DATA_W(16), .SKID_EN(0), .FLUSH_N(3), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .flush(b_fl),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occ(b_occ), .stall_cnt(b_cnt), .stall_clr(b_clr)
  );

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic [2:0]  fl;
    logic        clr;
    logic        ev;
    logic        dchk;
    logic [63:0] ed;
    logic [1:0]  eocc;
    logic        erdy;
    logic [3:0]  ecnt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic iv, logic [63:0] d, logic ordy,
    logic [2:0] fl, logic clr, logic ev,
    logic dchk, logic [63:0] ed, logic [1:0] eocc,
    logic erdy, logic [3:0] ecnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.fl = fl; v.clr = clr; v.ev = ev;
    v.dchk = dchk; v.ed = ed; v.eocc = eocc;
    v.erdy = erdy; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t        vt[$];
  logic [15:0] q[$];
  logic [15:0] seq;
  logic        pend;

  initial begin
    a_iv = 0; a_d = '0; a_or = 0; a_fl = '0; a_clr = 0;
    b_iv = 0; b_d = '0; b_or = 0; b_fl = '0; b_clr = 0;
    seq = '0; pend = 0;

    // stream
    for (int k = 1; k <= 8; k++)
      vt.push_back(mk(1'b1, 64'(k), 1'b1, 3'b0, 1'b0,
        1'b1, 1'b1, 64'(k), 2'd1, 1'b1, 4'd0));
    vt.push_back(mk(1'b0, 64'h0, 1'b1, 3'b0, 1'b0,
      1'b0, 1'b0, 64'h0, 2'd0, 1'b1, 4'd0));
    // skid fill and drain
    vt.push_back(mk(1'b1, 64'hA, 1'b0, 3'b0, 1'b0,
      1'b1, 1'b1, 64'hA, 2'd1, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 64'hB, 1'b0, 3'b0, 1'b0,
      1'b1, 1'b1, 64'hA, 2'd2, 1'b0, 4'd1));
    vt.push_back(mk(1'b0, 64'h0, 1'b0, 3'b0, 1'b0,
      1'b1, 1'b1, 64'hA, 2'd2, 1'b0, 4'd2));
    vt.push_back(mk(1'b0, 64'h0, 1'b0, 3'b0, 1'b0,
      1'b1, 1'b1, 64'hA, 2'd2, 1'b0, 4'd3));
    vt.push_back(mk(1'b0, 64'h0, 1'b1, 3'b0, 1'b0,
      1'b1, 1'b1, 64'hB, 2'd1, 1'b1, 4'd3));
    vt.push_back(mk(1'b0, 64'h0, 1'b1, 3'b0, 1'b0,
      1'b0, 1'b0, 64'h0, 2'd0, 1'b1, 4'd3));
    vt.push_back(mk(1'b0, 64'h0, 1'b1, 3'b0, 1'b1,
      1'b0, 1'b0, 64'h0, 2'd0, 1'b1, 4'd0));
    // flush from FULL with in_valid
    vt.push_back(mk(1'b1, 64'h11, 1'b0, 3'b0, 1'b0,
      1'b1, 1'b1, 64'h11, 2'd1, 1'b1, 4'd0));
    vt.push_back(mk(1'b1, 64'h12, 1'b0, 3'b0, 1'b0,
      1'b1, 1'b1, 64'h11, 2'd2, 1'b0, 4'd1));
    vt.push_back(mk(1'b1, 64'hC, 1'b0, 3'b010, 1'b0,
      1'b0, 1'b1, 64'h0, 2'd0, 1'b1, 4'd2));
    vt.push_back(mk(1'b0, 64'h0, 1'b0, 3'b0, 1'b0,
      1'b0, 1'b1, 64'h0, 2'd0, 1'b1, 4'd2));
    // flush discards a same-cycle accept
    vt.push_back(mk(1'b1, 64'h21, 1'b0, 3'b0, 1'b0,
      1'b1, 1'b1, 64'h21, 2'd1, 1'b1, 4'd2));
    vt.push_back(mk(1'b1, 64'h22, 1'b1, 3'b001, 1'b0,
      1'b0, 1'b1, 64'h0, 2'd0, 1'b1, 4'd2));
    vt.push_back(mk(1'b0, 64'h0, 1'b1, 3'b0, 1'b0,
      1'b0, 1'b1, 64'h0, 2'd0, 1'b1, 4'd2));
    // flush with stall_clr during a stall
    vt.push_back(mk(1'b1, 64'h31, 1'b0, 3'b0, 1'b0,
      1'b1, 1'b1, 64'h31, 2'd1, 1'b1, 4'd2));
    vt.push_back(mk(1'b0, 64'h0, 1'b0, 3'b100, 1'b1,
      1'b0, 1'b1, 64'h0, 2'd0, 1'b1, 4'd0));

    // reset values
    #12;
    chk("rst a_valid", 64'(a_ov), 64'd0);
    chk("rst a_data", a_od, 64'd0);
    chk("rst a_occ", 64'(a_occ), 64'd0);
    chk("rst a_ready", 64'(a_ir), 64'd1);
    chk("rst a_cnt", 64'(a_cnt), 64'd0);
    chk("rst b_valid", 64'(b_ov), 64'd0);
    chk("rst b_ready", 64'(b_ir), 64'd1);
    chk("rst b_occ", 64'(b_occ), 64'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      a_iv = vt[i].iv; a_d = vt[i].d; a_or = vt[i].ordy;
      a_fl = vt[i].fl; a_clr = vt[i].clr;
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i), 64'(a_ov), 64'(vt[i].ev));
      if (vt[i].dchk)
        chk($sformatf("v%0d data", i), a_od, vt[i].ed);
      chk($sformatf("v%0d occ", i), 64'(a_occ), 64'(vt[i].eocc));
      chk($sformatf("v%0d ready", i), 64'(a_ir), 64'(vt[i].erdy));
      chk($sformatf("v%0d cnt", i), 64'(a_cnt), 64'(vt[i].ecnt));
    end
    a_iv = 0; a_d = '0; a_or = 0; a_fl = '0; a_clr = 0;

    // no-skid streaming
    for (int k = 1; k <= 8; k++) begin
      b_iv = 1; b_d = 16'(k); b_or = 1;
      @(posedge clk); #1;
      chk($sformatf("b_stream%0d data", k), 64'(b_od), 64'(k));
      chk($sformatf("b_stream%0d occ", k), 64'(b_occ), 64'd1);
    end
    b_iv = 0;
    @(posedge clk); #1;
    chk("b_stream end valid", 64'(b_ov), 64'd0);
    chk("b_stream cnt", 64'(b_cnt), 64'd0);

    // no-skid random handshake scoreboard
    for (int c = 0; c < 100; c++) begin
      b_or = 1'($urandom_range(0, 1));
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend = 1;
        seq  = seq + 16'd1;
      end
      b_iv = pend; b_d = seq;
      #1;
      chk("b_rnd ready", 64'(b_ir),
          64'((q.size() == 0) || b_or));
      chk("b_rnd valid", 64'(b_ov), 64'(q.size() != 0));
      chk("b_rnd occ", 64'(b_occ), 64'(q.size()));
      if (b_or && (q.size() != 0)) begin
        chk("b_rnd data", 64'(b_od), 64'(q[0]));
        void'(q.pop_front());
      end
      if (b_iv && b_ir) begin
        q.push_back(b_d);
        pend = 0;
      end
      @(posedge clk); #1;
    end
    b_iv = 0; b_or = 1;
    #1;
    if (q.size() != 0) begin
      chk("b_drain data", 64'(b_od), 64'(q[0]));
      void'(q.pop_front());
    end
    @(posedge clk); #1;
    chk("b_drain valid", 64'(b_ov), 64'd0);

    // saturating stall counter
    a_iv = 1; a_d = 64'h41; a_or = 0;
    @(posedge clk); #1;
    a_iv = 0;
    chk("sat load occ", 64'(a_occ), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat cnt%0d", i), 64'(a_cnt),
          64'(((i + 1) > 15) ? 15 : (i + 1)));
    end
    chk("sat data held", a_od, 64'h41);
    a_clr = 1;
    @(posedge clk); #1;
    a_clr = 0;
    chk("sat clr", 64'(a_cnt), 64'd0);
    @(posedge clk); #1;
    chk("sat resume1", 64'(a_cnt), 64'd1);
    @(posedge clk); #1;
    chk("sat resume2", 64'(a_cnt), 64'd2);
    a_or = 1;
    @(posedge clk); #1;
    chk("sat drain", 64'(a_ov), 64'd0);

    // async reset while FULL
    a_or = 0; a_iv = 1; a_d = 64'h51;
    @(posedge clk); #1;
    a_d = 64'h52;
    @(posedge clk); #1;
    a_iv = 0;
    chk("ar full occ", 64'(a_occ), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("ar valid", 64'(a_ov), 64'd0);
    chk("ar data", a_od, 64'd0);
    chk("ar occ", 64'(a_occ), 64'd0);
    chk("ar ready", 64'(a_ir), 64'd1);
    chk("ar cnt", 64'(a_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ar post occ", 64'(a_occ), 64'd0);
    a_iv = 1; a_d = 64'h61; a_or = 1;
    @(posedge clk); #1;
    a_iv = 0;
    chk("ar first valid", 64'(a_ov), 64'd1);
    chk("ar first data", a_od, 64'h61);
    chk("ar first occ", 64'(a_occ), 64'd1);
    @(posedge clk); #1;
    chk("ar first drain", 64'(a_occ), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
